// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined N-input NAND.
package gf180mcu_fd_sc_mcu7t5v0__nandn_pkg;

  localparam int unsigned ARITY   = 3;
  localparam int unsigned NIN_MIN = 2;
  localparam int unsigned NIN_MAX = 27;
  localparam int unsigned NCH_MIN = 1;
  localparam int unsigned NCH_MAX = 32;

  function automatic int unsigned groups(input int unsigned n);
    return (n + ARITY - 1) / ARITY;
  endfunction

  // Tree depth: repeated grouping by three until a single term remains.
  function automatic int unsigned clog3(input int unsigned n);
    int unsigned w;
    int unsigned l;
    w = n;
    l = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (w > 1) begin
        w = groups(w);
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Per-channel width of tree level k (level 0 is the raw input).
  function automatic int unsigned level_width(input int unsigned n, input int unsigned k);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k) w = groups(w);
    end
    return w;
  endfunction

  function automatic bit params_legal(input int unsigned nin, input int unsigned nch);
    return (nin >= NIN_MIN) && (nin <= NIN_MAX) && (nch >= NCH_MIN) && (nch <= NCH_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_stage.sv
// One registered level of the 3-ary AND tree, with enable, valid bit and
// optional output inversion for the final level.
module gf180mcu_fd_sc_mcu7t5v0__and3_stage
  import gf180mcu_fd_sc_mcu7t5v0__nandn_pkg::*;
#(
  parameter  int unsigned NCH  = 1,
  parameter  int unsigned WIN  = 3,
  parameter  bit          INV  = 1'b0,
  localparam int unsigned WOUT = groups(WIN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                v_in,
  input  logic [NCH*WIN-1:0]  d_in,
  output logic                v_out,
  output logic [NCH*WOUT-1:0] d_out
);

  logic [NCH*WOUT-1:0] lvl;
  logic [3*WOUT-1:0]   ch_pad;
  logic [NCH*WOUT-1:0] data_d, data_q;
  logic                valid_d, valid_q;

  // A short trailing group is padded with ones so it does not mask the AND.
  always_comb begin
    lvl    = '0;
    ch_pad = '1;
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_pad          = '1;
      ch_pad[WIN-1:0] = d_in[c*WIN +: WIN];
      for (int unsigned g = 0; g < WOUT; g++) begin
        lvl[c*WOUT+g] = INV ^ (&ch_pad[g*3 +: 3]);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = v_in;
      data_d  = lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {(NCH*WOUT){INV}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign v_out = valid_q;
  assign d_out = data_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Pipelined multi-channel N-input NAND: LAT registered 3-ary AND levels with a
// collapsing valid/ready chain; the last level inverts and drives ZN.
module gf180mcu_fd_sc_mcu7t5v0__nandn_pipe
  import gf180mcu_fd_sc_mcu7t5v0__nandn_pkg::*;
#(
  parameter int unsigned NIN = 9,
  parameter int unsigned NCH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NCH*NIN-1:0] A,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [NCH-1:0]     ZN,
  output logic               OUT_VALID,
  input  logic               OUT_READY
);

  localparam int unsigned LAT = clog3(NIN);

  if (!params_legal(NIN, NCH)) begin : g_illegal_params
    $error("nandn_pipe: NIN=%0d or NCH=%0d outside legal range", NIN, NCH);
  end

  logic [LAT:1]   v;
  logic [LAT+1:1] rdy;

  // A stage may load when it is empty or when the stage after it will drain.
  always_comb begin
    rdy        = '0;
    rdy[LAT+1] = OUT_READY;
    for (int unsigned k = LAT; k >= 1; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    localparam int unsigned WIN  = level_width(NIN, k - 1);
    localparam int unsigned WOUT = level_width(NIN, k);

    logic [NCH*WIN-1:0]  d_in;
    logic                v_in;
    logic [NCH*WOUT-1:0] d_out;
    logic                v_out;

    if (k == 1) begin : g_src
      assign d_in = A;
      assign v_in = IN_VALID;
    end else begin : g_src
      assign d_in = g_stage[k-1].d_out;
      assign v_in = g_stage[k-1].v_out;
    end

    gf180mcu_fd_sc_mcu7t5v0__and3_stage #(
      .NCH (NCH),
      .WIN (WIN),
      .INV (k == LAT)
    ) u_stage (
      .clk   (CLK),
      .rst   (RST),
      .en    (rdy[k]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_out (v_out),
      .d_out (d_out)
    );

    assign v[k] = v_out;
  end

  assign IN_READY  = rdy[1];
  assign OUT_VALID = v[LAT];
  assign ZN        = g_stage[LAT].d_out;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Directed bench: main NIN=9/NCH=4 instance with a queue scoreboard, plus a
// NIN sweep of single-channel instances for latency and padding.
module tb_gf180mcu_fd_sc_mcu7t5v0__nandn_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [35:0] a;
  logic        iv, ir, ov, ordy;
  logic [3:0]  zn;

  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(9), .NCH(4)) dut (
    .CLK(CLK), .RST(RST), .A(a), .IN_VALID(iv), .IN_READY(ir),
    .ZN(zn), .OUT_VALID(ov), .OUT_READY(ordy)
  );

  logic        siv;
  logic [1:0]  a2;
  logic [2:0]  a3;
  logic [3:0]  a4;
  logic [9:0]  a10;
  logic [26:0] a27;
  logic [4:0]  sir, sov, szn;

  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(2), .NCH(1)) s0 (
    .CLK(CLK), .RST(RST), .A(a2), .IN_VALID(siv), .IN_READY(sir[0]),
    .ZN(szn[0:0]), .OUT_VALID(sov[0]), .OUT_READY(1'b1));
  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(3), .NCH(1)) s1 (
    .CLK(CLK), .RST(RST), .A(a3), .IN_VALID(siv), .IN_READY(sir[1]),
    .ZN(szn[1:1]), .OUT_VALID(sov[1]), .OUT_READY(1'b1));
  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(4), .NCH(1)) s2 (
    .CLK(CLK), .RST(RST), .A(a4), .IN_VALID(siv), .IN_READY(sir[2]),
    .ZN(szn[2:2]), .OUT_VALID(sov[2]), .OUT_READY(1'b1));
  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(10), .NCH(1)) s3 (
    .CLK(CLK), .RST(RST), .A(a10), .IN_VALID(siv), .IN_READY(sir[3]),
    .ZN(szn[3:3]), .OUT_VALID(sov[3]), .OUT_READY(1'b1));
  gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.NIN(27), .NCH(1)) s4 (
    .CLK(CLK), .RST(RST), .A(a27), .IN_VALID(siv), .IN_READY(sir[4]),
    .ZN(szn[4:4]), .OUT_VALID(sov[4]), .OUT_READY(1'b1));

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned n_pop  = 0;
  int unsigned cyc    = 0;
  logic [3:0]  q[$];
  int unsigned pop_hist[$];

  function automatic logic [3:0] nand4(input logic [35:0] x);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = ~&x[c*9 +: 9];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshake transfers into the scoreboard, then advance.
  task automatic tick();
    logic [3:0] e;
    #1;
    if (!RST && iv && ir) q.push_back(nand4(a));
    if (!RST && ov && ordy) begin
      if (q.size() == 0) begin
        chk("sb_depth", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sb_zn", 32'(zn), 32'(e));
        n_pop++;
        pop_hist.push_back(cyc);
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
    if (RST) q.delete();
  endtask

  logic [3:0]  hold_zn;
  int unsigned pops0;
  int unsigned first_lat[5];
  logic [4:0]  first_zn;
  int unsigned exp_lat[5] = '{1, 1, 2, 3, 3};
  int unsigned nin_tab[5] = '{2, 3, 4, 10, 27};

  initial begin
    RST = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0;
    siv = 1'b0; a2 = '0; a3 = '0; a4 = '0; a10 = '0; a27 = '0;

    // Reset
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_zn", 32'(zn), 32'hF);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_in_ready", 32'(ir), 32'd1);

    // Basic function and latency: ch0 ones, ch1 bit4 clear, ch2 zeros, ch3 ones
    a  = {9'h1FF, 9'h000, 9'h1EF, 9'h1FF};
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("basic_t1_out_valid", 32'(ov), 32'd0);
    tick();
    chk("basic_t2_out_valid", 32'(ov), 32'd1);
    chk("basic_t2_zn", 32'(zn), 32'h6);
    tick();
    tick();

    // Streaming 16 back-to-back operands
    pop_hist.delete();
    pops0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      a  = {4'($urandom_range(15)), $urandom()};
      iv = 1'b1;
      tick();
    end
    iv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stream_count", n_pop - pops0, 32'd16);
    if (pop_hist.size() == 16)
      chk("stream_span", pop_hist[15] - pop_hist[0], 32'd15);
    else
      chk("stream_hist", 32'(pop_hist.size()), 32'd16);

    // Backpressure
    pops0 = n_pop;
    ordy = 1'b0;
    a = {4'hA, 32'h1234_5678}; iv = 1'b1;
    hold_zn = nand4(a);
    tick();
    a = 36'hF_FFFF_FFFF;
    tick();
    a = {4'h3, 32'hFFFF_FE00};
    #1;
    chk("bp_full_in_ready", 32'(ir), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out_valid", 32'(ov), 32'd1);
      chk("bp_hold_zn", 32'(zn), 32'(hold_zn));
      chk("bp_hold_in_ready", 32'(ir), 32'd0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(ir), 32'd1);
    tick();
    iv = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_pop_count", n_pop - pops0, 32'd3);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two operands in flight
    ordy = 1'b0; iv = 1'b1;
    a = 36'h0_0000_0001; tick();
    a = 36'h7_7777_7777; tick();
    iv = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_out_valid", 32'(ov), 32'd0);
    chk("rst_mid_zn", 32'(zn), 32'hF);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_no_stale", 32'(ov), 32'd0);
    end

    // NIN sweep: pattern 0 = single zero at top index, pattern 1 = all ones
    for (int p = 0; p < 2; p++) begin
      a2 = '1; a3 = '1; a4 = '1; a10 = '1; a27 = '1;
      if (p == 0) begin
        a2[1] = 1'b0; a3[2] = 1'b0; a4[3] = 1'b0; a10[9] = 1'b0; a27[26] = 1'b0;
      end
      for (int i = 0; i < 5; i++) first_lat[i] = 0;
      first_zn = '0;
      siv = 1'b1;
      #1;
      chk($sformatf("sweep_p%0d_in_ready", p), 32'(sir), 32'h1F);
      tick();
      siv = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        for (int i = 0; i < 5; i++) begin
          if (sov[i] && first_lat[i] == 0) begin
            first_lat[i] = c;
            first_zn[i]  = szn[i];
          end
        end
        tick();
      end
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("sweep_p%0d_lat_nin%0d", p, nin_tab[i]), first_lat[i], exp_lat[i]);
        chk($sformatf("sweep_p%0d_zn_nin%0d", p, nin_tab[i]), 32'(first_zn[i]), (p == 0) ? 32'd1 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
